// File: rtl/jelly2_video_frame_generator.sv
// Video test-pattern generator: emits AXI4-Stream video frames with programmable
// geometry, line/frame blanking and a selectable pixel pattern.
module jelly2_video_frame_generator #(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 24,
    parameter int X_WIDTH     = 16,
    parameter int Y_WIDTH     = 16,
    parameter int BLANK_WIDTH = 16,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   areset,
    input  logic                   aclk,
    input  logic                   aclken,

    input  logic                   ctl_enable,
    output logic                   ctl_busy,
    output logic [FRAME_WIDTH-1:0] ctl_frame_count,

    input  logic [X_WIDTH-1:0]     param_width,
    input  logic [Y_WIDTH-1:0]     param_height,
    input  logic [BLANK_WIDTH-1:0] param_hblank,
    input  logic [BLANK_WIDTH-1:0] param_vblank,
    input  logic [1:0]             param_pattern,
    input  logic [TDATA_WIDTH-1:0] param_fill,

    output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
    output logic                   m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t                 state, state_next;
    logic [X_WIDTH-1:0]     x, x_next, width, width_next;
    logic [Y_WIDTH-1:0]     y, y_next, height, height_next;
    logic [BLANK_WIDTH-1:0] cnt, cnt_next, hblank, hblank_next, vblank, vblank_next;
    logic [1:0]             pattern, pattern_next;
    logic [TDATA_WIDTH-1:0] fill, fill_next;
    logic [FRAME_WIDTH-1:0] frame_next;
    logic                   frame_end;
    logic                   sof, sof_next, last_next, valid_next, busy_next;
    logic [TDATA_WIDTH-1:0] data_next;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            cnt             <= '0;
            width           <= '0;
            height          <= '0;
            hblank          <= '0;
            vblank          <= '0;
            pattern         <= '0;
            fill            <= '0;
            ctl_frame_count <= '0;
            ctl_busy        <= 1'b0;
            sof             <= 1'b0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tdata   <= '0;
            m_axi4s_tvalid  <= 1'b0;
        end else if (aclken) begin
            state           <= state_next;
            x               <= x_next;
            y               <= y_next;
            cnt             <= cnt_next;
            width           <= width_next;
            height          <= height_next;
            hblank          <= hblank_next;
            vblank          <= vblank_next;
            pattern         <= pattern_next;
            fill            <= fill_next;
            ctl_frame_count <= frame_next;
            ctl_busy        <= busy_next;
            sof             <= sof_next;
            m_axi4s_tlast   <= last_next;
            m_axi4s_tdata   <= data_next;
            m_axi4s_tvalid  <= valid_next;
        end
    end

    assign m_axi4s_tuser = TUSER_WIDTH'(sof);

    always_comb begin
        state_next   = state;
        x_next       = x;
        y_next       = y;
        cnt_next     = cnt;
        width_next   = width;
        height_next  = height;
        hblank_next  = hblank;
        vblank_next  = vblank;
        pattern_next = pattern;
        fill_next    = fill;
        frame_next   = ctl_frame_count;
        frame_end    = 1'b0;

        case (state)
            IDLE: frame_end = 1'b1;
            ACTIVE: begin
                if (m_axi4s_tvalid && m_axi4s_tready) begin
                    if (x == width - X_WIDTH'(1)) begin
                        x_next = '0;
                        if (y == height - Y_WIDTH'(1)) begin
                            y_next     = '0;
                            frame_next = ctl_frame_count + FRAME_WIDTH'(1);
                            if (vblank != '0) begin
                                state_next = VBLANK;
                                cnt_next   = vblank;
                            end else begin
                                frame_end = 1'b1;
                            end
                        end else begin
                            y_next = y + Y_WIDTH'(1);
                            if (hblank != '0) begin
                                state_next = HBLANK;
                                cnt_next   = hblank;
                            end
                        end
                    end else begin
                        x_next = x + X_WIDTH'(1);
                    end
                end
            end
            HBLANK: begin
                if (cnt == BLANK_WIDTH'(1)) state_next = ACTIVE;
                else                         cnt_next   = cnt - BLANK_WIDTH'(1);
            end
            VBLANK: begin
                if (cnt == BLANK_WIDTH'(1)) frame_end = 1'b1;
                else                         cnt_next  = cnt - BLANK_WIDTH'(1);
            end
            default: state_next = IDLE;
        endcase

        // IDLE and every frame boundary share one start decision, so params relatch here only
        if (frame_end) begin
            if (ctl_enable && param_width != '0 && param_height != '0) begin
                state_next   = ACTIVE;
                x_next       = '0;
                y_next       = '0;
                width_next   = param_width;
                height_next  = param_height;
                hblank_next  = param_hblank;
                vblank_next  = param_vblank;
                pattern_next = param_pattern;
                fill_next    = param_fill;
            end else begin
                state_next = IDLE;
            end
        end

        // Outputs are precomputed from the next pixel so the port registers carry the beat
        valid_next = (state_next == ACTIVE);
        busy_next  = (state_next != IDLE);
        sof_next   = valid_next && x_next == '0 && y_next == '0;
        last_next  = valid_next && (x_next == width_next - X_WIDTH'(1));
        data_next  = '0;
        if (valid_next) begin
            case (pattern_next)
                2'd0:    data_next = fill_next;
                2'd1:    data_next = TDATA_WIDTH'(x_next);
                2'd2:    data_next = TDATA_WIDTH'(y_next);
                default: data_next = TDATA_WIDTH'(x_next) + TDATA_WIDTH'(y_next)
                                   + TDATA_WIDTH'(frame_next);
            endcase
        end
    end

endmodule

// File: tb/tb_jelly2_video_frame_generator.sv
// Directed self-checking bench for jelly2_video_frame_generator; inputs change and
// outputs are sampled on the falling clock edge.
module tb_jelly2_video_frame_generator;

    logic        areset;
    logic        aclk;
    logic        aclken;
    logic        ctl_enable;
    logic        ctl_busy;
    logic [15:0] ctl_frame_count;
    logic [15:0] param_width;
    logic [15:0] param_height;
    logic [15:0] param_hblank;
    logic [15:0] param_vblank;
    logic [1:0]  param_pattern;
    logic [23:0] param_fill;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast;
    logic [23:0] m_axi4s_tdata;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready;

    int n_checks = 0;
    int n_errors = 0;
    int exp_fc   = 0;

    jelly2_video_frame_generator #(
        .TUSER_WIDTH (1),
        .TDATA_WIDTH (24),
        .X_WIDTH     (16),
        .Y_WIDTH     (16),
        .BLANK_WIDTH (16),
        .FRAME_WIDTH (16)
    ) dut (
        .areset          (areset),
        .aclk            (aclk),
        .aclken          (aclken),
        .ctl_enable      (ctl_enable),
        .ctl_busy        (ctl_busy),
        .ctl_frame_count (ctl_frame_count),
        .param_width     (param_width),
        .param_height    (param_height),
        .param_hblank    (param_hblank),
        .param_vblank    (param_vblank),
        .param_pattern   (param_pattern),
        .param_fill      (param_fill),
        .m_axi4s_tuser   (m_axi4s_tuser),
        .m_axi4s_tlast   (m_axi4s_tlast),
        .m_axi4s_tdata   (m_axi4s_tdata),
        .m_axi4s_tvalid  (m_axi4s_tvalid),
        .m_axi4s_tready  (m_axi4s_tready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    function automatic logic [63:0] beat(input logic v, input logic u, input logic l,
                                         input logic [23:0] d);
        return {37'd0, v, u, l, d};
    endfunction

    function automatic logic [63:0] obs();
        return {37'd0, m_axi4s_tvalid, m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata};
    endfunction

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 200 && ctl_busy; c++) step();
        check(tag, {63'd0, ctl_busy}, 64'd0);
    endtask

    task automatic set_params(input int w, input int h, input int hb, input int vb,
                              input int pat, input logic [23:0] fill);
        param_width   = 16'(w);
        param_height  = 16'(h);
        param_hblank  = 16'(hb);
        param_vblank  = 16'(vb);
        param_pattern = 2'(pat);
        param_fill    = fill;
    endtask

    initial begin
        logic [63:0] held;
        logic        stalled;
        int          idx;
        int          beats;

        areset = 1'b0;
        aclken = 1'b1;
        ctl_enable = 1'b0;
        m_axi4s_tready = 1'b1;
        set_params(0, 0, 0, 0, 0, 24'd0);
        #1 areset = 1'b1;
        #1;
        check("reset_out", obs(), 64'd0);
        check("reset_busy_fc", {47'd0, ctl_busy, ctl_frame_count}, 64'd0);
        step(); step();
        areset = 1'b0;

        // zero geometry must not start
        ctl_enable = 1'b1;
        set_params(0, 2, 0, 0, 1, 24'd0);
        step(); step();
        check("zero_w_idle", {62'd0, ctl_busy, m_axi4s_tvalid}, 64'd0);
        set_params(4, 0, 0, 0, 1, 24'd0);
        step(); step();
        check("zero_h_idle", {62'd0, ctl_busy, m_axi4s_tvalid}, 64'd0);
        ctl_enable = 1'b0;
        step();

        // T1: 4x2 back-to-back, pattern x
        set_params(4, 2, 0, 0, 1, 24'd0);
        ctl_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_beat", obs(), beat(1'b1, i == 0, (i % 4) == 3, 24'(i % 4)));
        end
        step();
        check("t1_sof2", obs(), beat(1'b1, 1'b1, 1'b0, 24'd0));
        check("t1_fc", 64'(ctl_frame_count), 64'(exp_fc + 1));
        ctl_enable = 1'b0;
        wait_idle("t1_idle");
        exp_fc += 2;
        check("t1_fc_end", 64'(ctl_frame_count), 64'(exp_fc));

        // T2: 3x3 with hblank 2, vblank 5, pattern y
        set_params(3, 3, 2, 5, 2, 24'd0);
        ctl_enable = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int x = 0; x < 3; x++) begin
                step();
                check("t2_beat", obs(), beat(1'b1, l == 0 && x == 0, x == 2, 24'(l)));
            end
            for (int g = 0; g < (l < 2 ? 2 : 5); g++) begin
                step();
                check("t2_gap", {62'd0, ctl_busy, m_axi4s_tvalid}, 64'd2);
            end
        end
        step();
        check("t2_sof2", obs(), beat(1'b1, 1'b1, 1'b0, 24'd0));
        ctl_enable = 1'b0;
        wait_idle("t2_idle");
        exp_fc += 2;
        check("t2_fc_end", 64'(ctl_frame_count), 64'(exp_fc));

        // T3: random backpressure, 5x3, pattern x+y+frame
        set_params(5, 3, 1, 2, 3, 24'd0);
        ctl_enable = 1'b1;
        stalled = 1'b0;
        held = '0;
        idx = 0;
        for (int c = 0; c < 600 && idx < 15; c++) begin
            step();
            if (c == 0) ctl_enable = 1'b0;
            if (stalled && m_axi4s_tvalid) check("t3_stable", obs(), held);
            m_axi4s_tready = 1'($urandom_range(0, 1));
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                check("t3_beat", obs(), beat(1'b1, idx == 0, (idx % 5) == 4,
                                             24'((idx % 5) + (idx / 5) + exp_fc)));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = m_axi4s_tvalid;
                held = obs();
            end
        end
        check("t3_count", 64'(idx), 64'd15);
        m_axi4s_tready = 1'b1;
        wait_idle("t3_idle");
        exp_fc += 1;
        check("t3_fc_end", 64'(ctl_frame_count), 64'(exp_fc));

        // T4: 1x1 frames, solid fill
        set_params(1, 1, 0, 0, 0, 24'hABCDEF);
        ctl_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_beat", obs(), beat(1'b1, 1'b1, 1'b1, 24'hABCDEF));
        end
        ctl_enable = 1'b0;
        wait_idle("t4_idle");
        exp_fc += 4;
        check("t4_fc_end", 64'(ctl_frame_count), 64'(exp_fc));

        // T5: enable dropped on line 1 of 4; width change lands on the next frame
        set_params(2, 4, 1, 3, 1, 24'd0);
        ctl_enable = 1'b1;
        step(); check("t5_b0", obs(), beat(1'b1, 1'b1, 1'b0, 24'd0));
        step(); check("t5_b1", obs(), beat(1'b1, 1'b0, 1'b1, 24'd1));
        step(); check("t5_hgap", {63'd0, m_axi4s_tvalid}, 64'd0);
        step(); check("t5_l1", obs(), beat(1'b1, 1'b0, 1'b0, 24'd0));
        ctl_enable = 1'b0;
        param_width = 16'd3;
        beats = 0;
        for (int n = 5; n <= 15; n++) begin
            step();
            if (m_axi4s_tvalid) begin
                beats++;
                check("t5_x_range", {63'd0, m_axi4s_tdata > 24'd1}, 64'd0);
            end
            if (n == 14) check("t5_vblank_busy", {62'd0, ctl_busy, m_axi4s_tvalid}, 64'd2);
            if (n == 15) check("t5_busy_fall", {63'd0, ctl_busy}, 64'd0);
        end
        check("t5_beats", 64'(beats), 64'd5);
        exp_fc += 1;
        check("t5_fc", 64'(ctl_frame_count), 64'(exp_fc));
        ctl_enable = 1'b1;
        step(); check("t5_n0", obs(), beat(1'b1, 1'b1, 1'b0, 24'd0));
        ctl_enable = 1'b0;
        step(); check("t5_n1", obs(), beat(1'b1, 1'b0, 1'b0, 24'd1));
        step(); check("t5_n2", obs(), beat(1'b1, 1'b0, 1'b1, 24'd2));
        wait_idle("t5_idle");
        exp_fc += 1;

        // T6: asynchronous reset mid-line
        set_params(4, 2, 0, 0, 1, 24'd0);
        ctl_enable = 1'b1;
        step(); step();
        check("t6_pre", obs(), beat(1'b1, 1'b0, 1'b0, 24'd1));
        #2 areset = 1'b1;
        #1;
        check("t6_async_out", obs(), 64'd0);
        check("t6_async_busy_fc", {47'd0, ctl_busy, ctl_frame_count}, 64'd0);
        exp_fc = 0;
        step(); step();
        areset = 1'b0;
        step();
        check("t6_restart", obs(), beat(1'b1, 1'b1, 1'b0, 24'd0));
        ctl_enable = 1'b0;
        wait_idle("t6_idle");
        exp_fc += 1;
        check("t6_fc_end", 64'(ctl_frame_count), 64'(exp_fc));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
